// File: rtl/spi_minion_adapter.sv
// SPI minion push/pull packet interface bridged to a val/rdy send/recv stream pair.
// Optional dropped-write counter (err_count port) is enabled by defining SPI_V3_ADAPTER_ERRCNT_EN.
module spi_minion_adapter #(
  parameter int nbits       = 32,
  parameter int num_entries = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic [nbits+1:0] push_msg,
  input  logic             pull_en,
  output logic [nbits+1:0] pull_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg
`ifdef SPI_V3_ADAPTER_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int CW = $clog2(num_entries + 1);
  localparam int PW = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(num_entries);
  localparam logic [PW-1:0] LAST  = PW'(num_entries - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  logic [nbits-1:0] r_wq_mem [num_entries];
  logic [PW-1:0]    r_wq_head;
  logic [PW-1:0]    r_wq_tail;
  logic [CW-1:0]    r_wq_cnt;

  logic [nbits-1:0] r_rq_mem [num_entries];
  logic [PW-1:0]    r_rq_head;
  logic [PW-1:0]    r_rq_tail;
  logic [CW-1:0]    r_rq_cnt;

  logic             r_armed;

  logic             w_val_wrt;
  logic             w_val_rd;
  logic             w_wq_full;
  logic             w_wq_enq;
  logic             w_wq_deq;
  logic             w_rq_enq;
  logic             w_rq_deq;
  logic             w_pull_val;
  logic [nbits-1:0] w_wq_head_data;
  logic [nbits-1:0] w_rq_head_data;

  assign w_val_wrt      = push_msg[nbits+1];
  assign w_val_rd       = push_msg[nbits];
  assign w_wq_full      = (r_wq_cnt == DEPTH);
  assign w_wq_head_data = r_wq_mem[r_wq_head];
  assign w_rq_head_data = r_rq_mem[r_rq_head];

  // Fullness is judged on registered state only: a same-cycle dequeue never makes room.
  assign w_wq_enq = push_en & w_val_wrt & ~w_wq_full;
  assign w_wq_deq = send_val & send_rdy;

  assign send_val = (r_wq_cnt != {CW{1'b0}});
  assign send_msg = send_val ? w_wq_head_data : {nbits{1'b0}};

  assign recv_rdy = (r_rq_cnt != DEPTH);
  assign w_rq_enq = recv_val & recv_rdy;

  assign w_pull_val = r_armed & (r_rq_cnt != {CW{1'b0}});
  assign w_rq_deq   = pull_en & w_pull_val;
  assign pull_msg   = {~w_wq_full, w_pull_val, (w_pull_val ? w_rq_head_data : {nbits{1'b0}})};

  // Write queue: master packets waiting for the downstream block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wq_head <= '0;
      r_wq_tail <= '0;
      r_wq_cnt  <= '0;
      for (int i = 0; i < num_entries; i++) begin
        r_wq_mem[i] <= '0;
      end
    end else begin
      if (w_wq_enq) begin
        r_wq_mem[r_wq_tail] <= push_msg[nbits-1:0];
        r_wq_tail           <= ptr_inc(r_wq_tail);
      end
      if (w_wq_deq) begin
        r_wq_head <= ptr_inc(r_wq_head);
      end
      case ({w_wq_enq, w_wq_deq})
        2'b10:   r_wq_cnt <= r_wq_cnt + CW'(1);
        2'b01:   r_wq_cnt <= r_wq_cnt - CW'(1);
        default: r_wq_cnt <= r_wq_cnt;
      endcase
    end
  end

  // Read queue: downstream responses waiting for an armed pull.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rq_head <= '0;
      r_rq_tail <= '0;
      r_rq_cnt  <= '0;
      for (int i = 0; i < num_entries; i++) begin
        r_rq_mem[i] <= '0;
      end
    end else begin
      if (w_rq_enq) begin
        r_rq_mem[r_rq_tail] <= recv_msg;
        r_rq_tail           <= ptr_inc(r_rq_tail);
      end
      if (w_rq_deq) begin
        r_rq_head <= ptr_inc(r_rq_head);
      end
      case ({w_rq_enq, w_rq_deq})
        2'b10:   r_rq_cnt <= r_rq_cnt + CW'(1);
        2'b01:   r_rq_cnt <= r_rq_cnt - CW'(1);
        default: r_rq_cnt <= r_rq_cnt;
      endcase
    end
  end

  // A new read request outranks the pull that consumes the previous one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (push_en & w_val_rd) begin
      r_armed <= 1'b1;
    end else if (w_rq_deq) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= r_armed;
    end
  end

`ifdef SPI_V3_ADAPTER_ERRCNT_EN
  logic       w_wq_drop;
  logic [7:0] r_err_cnt;

  assign w_wq_drop = push_en & w_val_wrt & w_wq_full;
  assign err_count = r_err_cnt;

  // Saturating count of writes lost to a full write queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_wq_drop && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_spi_minion_adapter.sv
// Bench for spi_minion_adapter: directed vector table, err_count saturation, then random traffic against a queue model.
module tb_spi_minion_adapter;

  localparam int NB = 32;
  localparam int NE = 2;

  logic          clk;
  logic          reset;
  logic          push_en;
  logic [NB+1:0] push_msg;
  logic          pull_en;
  logic [NB+1:0] pull_msg;
  logic          send_val;
  logic          send_rdy;
  logic [NB-1:0] send_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [NB-1:0] recv_msg;
`ifdef SPI_V3_ADAPTER_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  spi_minion_adapter #(.nbits(NB), .num_entries(NE)) dut (
    .clk      (clk),
    .reset    (reset),
    .push_en  (push_en),
    .push_msg (push_msg),
    .pull_en  (pull_en),
    .pull_msg (pull_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg)
`ifdef SPI_V3_ADAPTER_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          pe;
    logic [NB+1:0] pm;
    logic          pl;
    logic          sr;
    logic          rv;
    logic [NB-1:0] rm;
    logic [NB+1:0] e_pull;
    logic          e_sv;
    logic [NB-1:0] e_sm;
    logic          e_rr;
    logic [7:0]    e_err;
  } vec_t;

  vec_t tbl [31];
  int   n_vec = 0;
  int   n_err = 0;

  logic [NB-1:0] wq_m [$];
  logic [NB-1:0] rq_m [$];
  logic          armed_m;
  int            err_m;

  function automatic logic [NB+1:0] wr(input logic [NB-1:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [NB+1:0] pk(input logic s, input logic v, input logic [NB-1:0] d);
    return {s, v, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic pe, input logic [NB+1:0] pm,
                       input logic pl, input logic sr, input logic rv, input logic [NB-1:0] rm);
    reset    = rst;
    push_en  = pe;
    push_msg = pm;
    pull_en  = pl;
    send_rdy = sr;
    recv_val = rv;
    recv_msg = rm;
  endtask

  // Reference model: queues plus the armed flag, advanced once per clock from the current inputs.
  task automatic model_step();
    bit wfull, sdeq, rdy, pv, rdeq;
    if (reset) begin
      wq_m.delete();
      rq_m.delete();
      armed_m = 1'b0;
      err_m   = 0;
    end else begin
      wfull = (wq_m.size() >= NE);
      sdeq  = (wq_m.size() != 0) && send_rdy;
      rdy   = (rq_m.size() < NE);
      pv    = armed_m && (rq_m.size() != 0);
      rdeq  = pull_en && pv;
      if (sdeq) void'(wq_m.pop_front());
      if (push_en && push_msg[NB+1]) begin
        if (!wfull) wq_m.push_back(push_msg[NB-1:0]);
        else if (err_m < 255) err_m++;
      end
      if (rdeq) void'(rq_m.pop_front());
      if (recv_val && rdy) rq_m.push_back(recv_msg);
      if (push_en && push_msg[NB]) armed_m = 1'b1;
      else if (rdeq) armed_m = 1'b0;
    end
  endtask

  task automatic model_check();
    bit            pv;
    logic [NB+1:0] ep;
    pv = armed_m && (rq_m.size() != 0);
    ep = pk(wq_m.size() < NE, pv, pv ? rq_m[0] : 32'h0);
    chk("rnd_pull_msg", 64'(pull_msg), 64'(ep));
    chk("rnd_send_val", 64'(send_val), 64'(wq_m.size() != 0));
    if (wq_m.size() != 0) chk("rnd_send_msg", 64'(send_msg), 64'(wq_m[0]));
    chk("rnd_recv_rdy", 64'(recv_rdy), 64'(rq_m.size() < NE));
`ifdef SPI_V3_ADAPTER_ERRCNT_EN
    chk("rnd_err_count", 64'(err_count), 64'(err_m));
`endif
  endtask

  initial begin
    //             rst   pe    pm                     pl    sr    rv    rm            e_pull                    e_sv  e_sm          e_rr  e_err
    tbl[0]  = '{1'b0, 1'b1, wr(32'hA5A5A5A5), 1'b0, 1'b1, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b1, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b1, 32'hA5A5A5A5, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, wr(32'h11111111), 1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, wr(32'h22222222), 1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b1, 32'h11111111, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, wr(32'h33333333), 1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b0,1'b0,32'h0),        1'b1, 32'h11111111, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, wr(32'h33333334), 1'b0, 1'b1, 1'b0, 32'h0,        pk(1'b0,1'b0,32'h0),        1'b1, 32'h11111111, 1'b1, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b1, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b1, 32'h22222222, 1'b1, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'h12345678, pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[8]  = '{1'b0, 1'b1, {2'b01,32'h0},    1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[9]  = '{1'b0, 1'b0, 34'h0,            1'b1, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b1,32'h12345678), 1'b0, 32'h0,        1'b1, 8'd2};
    tbl[10] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[11] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hCAFEF00D, pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[12] = '{1'b0, 1'b0, 34'h0,            1'b1, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[13] = '{1'b0, 1'b1, {2'b01,32'h0},    1'b1, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[14] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b1,32'hCAFEF00D), 1'b0, 32'h0,        1'b1, 8'd2};
    tbl[15] = '{1'b0, 1'b1, {2'b01,32'h0},    1'b1, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b1,32'hCAFEF00D), 1'b0, 32'h0,        1'b1, 8'd2};
    tbl[16] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hBEEF0001, pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[17] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b1,32'hBEEF0001), 1'b0, 32'h0,        1'b1, 8'd2};
    tbl[18] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hBEEF0002, pk(1'b1,1'b1,32'hBEEF0001), 1'b0, 32'h0,        1'b1, 8'd2};
    tbl[19] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hBEEF0003, pk(1'b1,1'b1,32'hBEEF0001), 1'b0, 32'h0,        1'b0, 8'd2};
    tbl[20] = '{1'b0, 1'b0, 34'h0,            1'b1, 1'b0, 1'b1, 32'hBEEF0004, pk(1'b1,1'b1,32'hBEEF0001), 1'b0, 32'h0,        1'b0, 8'd2};
    tbl[21] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hBEEF0005, pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd2};
    tbl[22] = '{1'b0, 1'b1, {2'b11,32'h44444444}, 1'b0, 1'b0, 1'b0, 32'h0,    pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b0, 8'd2};
    tbl[23] = '{1'b0, 1'b0, 34'h0,            1'b1, 1'b0, 1'b1, 32'hBEEF0006, pk(1'b1,1'b1,32'hBEEF0002), 1'b1, 32'h44444444, 1'b0, 8'd2};
    tbl[24] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'hBEEF0007, pk(1'b1,1'b0,32'h0),        1'b1, 32'h44444444, 1'b1, 8'd2};
    tbl[25] = '{1'b1, 1'b1, {2'b11,32'h55555555}, 1'b1, 1'b1, 1'b1, 32'hBEEF0008, pk(1'b1,1'b0,32'h0),    1'b1, 32'h44444444, 1'b0, 8'd2};
    tbl[26] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[27] = '{1'b0, 1'b1, {2'b01,32'h0},    1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[28] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[29] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b1, 32'h0BADF00D, pk(1'b1,1'b0,32'h0),        1'b0, 32'h0,        1'b1, 8'd0};
    tbl[30] = '{1'b0, 1'b0, 34'h0,            1'b0, 1'b0, 1'b0, 32'h0,        pk(1'b1,1'b1,32'h0BADF00D), 1'b0, 32'h0,        1'b1, 8'd0};

    drive(1'b1, 1'b0, 34'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 31; i++) begin
      chk($sformatf("tbl%0d_pull_msg", i), 64'(pull_msg), 64'(tbl[i].e_pull));
      chk($sformatf("tbl%0d_send_val", i), 64'(send_val), 64'(tbl[i].e_sv));
      if (tbl[i].e_sv || i == 0 || i == 26)
        chk($sformatf("tbl%0d_send_msg", i), 64'(send_msg), 64'(tbl[i].e_sm));
      chk($sformatf("tbl%0d_recv_rdy", i), 64'(recv_rdy), 64'(tbl[i].e_rr));
`ifdef SPI_V3_ADAPTER_ERRCNT_EN
      chk($sformatf("tbl%0d_err_count", i), 64'(err_count), 64'(tbl[i].e_err));
`endif
      drive(tbl[i].rst, tbl[i].pe, tbl[i].pm, tbl[i].pl, tbl[i].sr, tbl[i].rv, tbl[i].rm);
      @(negedge clk);
    end

`ifdef SPI_V3_ADAPTER_ERRCNT_EN
    // Drop counter must stop at 255 rather than wrap.
    drive(1'b1, 1'b0, 34'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, wr(32'(i)), 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
    chk("sat_err_254", 64'(err_count), 64'd254);
    for (int i = 0; i < 46; i++) begin
      drive(1'b0, 1'b1, wr(32'(i)), 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
    chk("sat_err_255", 64'(err_count), 64'd255);
`endif

    drive(1'b1, 1'b0, 34'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_step();
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      model_check();
      drive(($urandom_range(199) == 0),
            ($urandom_range(1) == 1),
            {1'($urandom_range(1)), 1'($urandom_range(3) == 0), 32'($urandom)},
            ($urandom_range(4) < 2),
            ($urandom_range(1) == 1),
            ($urandom_range(1) == 1),
            32'($urandom));
      model_step();
      @(negedge clk);
    end
    model_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
